muldiv_unit: RTL and testbench

- Iterative RV32M-style multiply/divide execution unit, parametrised in operand width and bits retired per cycle.
- Sits beside the single-cycle ALU in the EX stage. The EX stage issues an op with `start`, stalls on `busy`, and captures `result` on `done`.
- Adds multi-cycle arithmetic, RISC-V special-case semantics and squash-on-flush, none of which the single-cycle ALU provides.

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: shift-add multiply, restoring divide,
// BITS_PER_CYCLE bits retired per iteration, RISC-V divide special cases, flush squash.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_mag_a;
  logic [XLEN-1:0]   r_mag_b;
  logic [2*XLEN-1:0] r_acc;
  logic [2:0]        r_funct3;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_result;

  // Operand decode on the raw inputs, used only when a start is accepted in IDLE
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;

  assign w_a_signed = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
  assign w_b_signed = (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
  assign w_a_neg    = w_a_signed & op_a[XLEN-1];
  assign w_b_neg    = w_b_signed & op_b[XLEN-1];
  assign w_mag_a    = w_a_neg ? -op_a : op_a;
  assign w_mag_b    = w_b_neg ? -op_b : op_b;
  assign w_div_zero = funct3[2] && (op_b == '0);
  assign w_div_ovf  = (funct3 == 3'b100 || funct3 == 3'b110) && (op_a == MIN_NEG) && (op_b == '1);
  assign w_special  = w_div_zero | w_div_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) w_special_res = funct3[1] ? op_a : '1;
    else            w_special_res = funct3[1] ? '0 : op_a;
  end

  // Unrolled iteration chain; the accumulator holds {hi, lo} for both operations
  logic [2*XLEN-1:0] w_mul_stg [0:BITS_PER_CYCLE];
  logic [2*XLEN-1:0] w_div_stg [0:BITS_PER_CYCLE];

  assign w_mul_stg[0] = r_acc;
  assign w_div_stg[0] = r_acc;

  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      logic [XLEN:0] w_sum;
      logic [XLEN:0] w_shift;
      logic [XLEN:0] w_diff;

      assign w_sum = {1'b0, w_mul_stg[gi][2*XLEN-1:XLEN]}
                   + (w_mul_stg[gi][0] ? {1'b0, r_mag_a} : '0);
      assign w_mul_stg[gi+1] = {w_sum, w_mul_stg[gi][XLEN-1:1]};

      // Remainder stays below the divisor, so the borrow bit alone decides restore
      assign w_shift = w_div_stg[gi][2*XLEN-1:XLEN-1];
      assign w_diff  = w_shift - {1'b0, r_mag_b};
      assign w_div_stg[gi+1] = w_diff[XLEN]
                             ? {w_shift[XLEN-1:0], w_div_stg[gi][XLEN-2:0], 1'b0}
                             : {w_diff[XLEN-1:0],  w_div_stg[gi][XLEN-2:0], 1'b1};
    end
  endgenerate

  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_acc_next = r_funct3[2] ? w_div_stg[BITS_PER_CYCLE] : w_mul_stg[BITS_PER_CYCLE];
  assign w_prod     = r_neg_q ? -w_mul_stg[BITS_PER_CYCLE] : w_mul_stg[BITS_PER_CYCLE];
  assign w_quo      = w_div_stg[BITS_PER_CYCLE][XLEN-1:0];
  assign w_rem      = w_div_stg[BITS_PER_CYCLE][2*XLEN-1:XLEN];

  always_comb begin
    w_final = '0;
    case (r_funct3)
      3'b000:                 w_final = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = r_neg_q ? -w_quo : w_quo;
      default:                w_final = r_neg_r ? -w_rem : w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_funct3 <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_special) begin
              r_result <= w_special_res;
              r_state  <= DONE;
            end else begin
              r_mag_a  <= w_mag_a;
              r_mag_b  <= w_mag_b;
              r_funct3 <= funct3;
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_acc    <= funct3[2] ? {{XLEN{1'b0}}, w_mag_a} : {{XLEN{1'b0}}, w_mag_b};
              r_cnt    <= CW'(N);
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result <= w_final;
            r_state  <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = (r_state == CALC);
  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: three instances (32x1, 32x4, 16x1), directed vectors,
// a monitor popping expected results/done cycles whenever done is seen.
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic        st0 = 1'b0, fl0 = 1'b0;
  logic [2:0]  f0 = '0;
  logic [31:0] a0 = '0, b0 = '0;
  logic        st1 = 1'b0;
  logic [2:0]  f1 = '0;
  logic [31:0] a1 = '0, b1 = '0;
  logic        st2 = 1'b0;
  logic [2:0]  f2 = '0;
  logic [15:0] a2 = '0, b2 = '0;
  logic        fl_off = 1'b0;

  logic        busy0, done0, busy1, done1, busy2, done2;
  logic [31:0] res0, res1;
  logic [15:0] res2;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u0 (
    .clk(clk), .rst(rst), .start(st0), .funct3(f0), .op_a(a0), .op_b(b0),
    .flush(fl0), .busy(busy0), .done(done0), .result(res0));
  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u1 (
    .clk(clk), .rst(rst), .start(st1), .funct3(f1), .op_a(a1), .op_b(b1),
    .flush(fl_off), .busy(busy1), .done(done1), .result(res1));
  muldiv_unit #(.XLEN(16), .BITS_PER_CYCLE(1)) u2 (
    .clk(clk), .rst(rst), .start(st2), .funct3(f2), .op_a(a2), .op_b(b2),
    .flush(fl_off), .busy(busy2), .done(done2), .result(res2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] res_of(int w);
    case (w)
      0:       return res0;
      1:       return res1;
      default: return {16'h0, res2};
    endcase
  endfunction

  function automatic logic busy_of(int w);
    case (w)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic done_of(int w);
    case (w)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic int sb_size(int w);
    case (w)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic set_in(input int w, input logic s, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b);
    case (w)
      0:       begin st0 = s; f0 = f; a0 = a; b0 = b; end
      1:       begin st1 = s; f1 = f; a1 = a; b1 = b; end
      default: begin st2 = s; f2 = f; a2 = a[15:0]; b2 = b[15:0]; end
    endcase
  endtask

  task automatic push(input int w, input exp_t e);
    case (w)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic pop(input int w, output exp_t e);
    case (w)
      0:       e = sb0.pop_front();
      1:       e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end else begin
      $display("ok   %s = %h", nm, got);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  task automatic check_pop(input int w);
    exp_t e;
    if (sb_size(w) == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL stray_done[%0d]: got done at cycle %0d want no done", w, cyc);
    end else begin
      pop(w, e);
      chk($sformatf("%s.result", e.name), res_of(w), e.res);
      n_vec++;
      if (cyc != e.cyc) begin
        n_bad++;
        $display("FAIL %s.done_cycle: got %0d want %0d", e.name, cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int w = 0; w < 3; w++)
      if (done_of(w)) check_pop(w);
  end

  task automatic wait_done(input int w, input string nm, input int exp_busy);
    int k;
    int bsy;
    bsy = 0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy_of(w)) bsy++;
      if (done_of(w)) break;
    end
    n_vec++;
    if (k == 100 || bsy != exp_busy) begin
      n_bad++;
      $display("FAIL %s.busy_cycles: got %0d (timeout=%0d) want %0d", nm, bsy, k == 100, exp_busy);
    end
  endtask

  // Issue one op; operands and funct3 are scrambled while busy to show they are not re-sampled
  task automatic run_op(input int w, input string nm, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input bit special);
    int   n;
    exp_t e;
    n = (w == 0) ? 32 : (w == 1) ? 8 : 16;
    @(posedge clk); #1;
    set_in(w, 1'b1, f, a, b);
    e.res  = exp_res;
    e.cyc  = cyc + (special ? 1 : n + 1);
    e.name = nm;
    push(w, e);
    @(posedge clk); #1;
    set_in(w, 1'b0, ~f, ~a, ~b);
    wait_done(w, nm, special ? 0 : n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] prev;
    exp_t        e;
    int          c0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("reset.busy[%0d]", w), {31'b0, busy_of(w)}, 32'h0);
      chk($sformatf("reset.done[%0d]", w), {31'b0, done_of(w)}, 32'h0);
      chk($sformatf("reset.result[%0d]", w), res_of(w), 32'h0);
    end

    run_op(0, "mul",        MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run_op(0, "mulhu",      MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op(0, "mulh_min",   MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    run_op(0, "mulhsu",     MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    run_op(0, "mulh_neg",   MULH,   32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 1'b0);
    run_op(0, "div",        DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0);
    run_op(0, "rem",        REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0);
    run_op(0, "divu",       DIVU,   32'd100,      32'd7,        32'd14,       1'b0);
    run_op(0, "remu",       REMU,   32'd100,      32'd7,        32'd2,        1'b0);
    run_op(0, "div_negb",   DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);
    run_op(0, "rem_nega",   REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 1'b0);
    run_op(0, "divu_zero",  DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
    run_op(0, "rem_zero",   REM,    32'd5,        32'd0,        32'd5,        1'b1);
    run_op(0, "div_ovf",    DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    run_op(0, "rem_ovf",    REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1);

    run_op(1, "b4.mul",     MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    run_op(1, "b4.mulhu",   MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op(1, "b4.div",     DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0);
    run_op(1, "b4.remu",    REMU,   32'd100,      32'd7,        32'd2,        1'b0);

    run_op(2, "x16.div_ovf", DIV,   32'h00008000, 32'h0000FFFF, 32'h00008000, 1'b1);
    run_op(2, "x16.div",     DIV,   32'h0000FFF9, 32'h00000002, 32'h0000FFFD, 1'b0);
    run_op(2, "x16.mul",     MUL,   32'h00000007, 32'h0000FFFD, 32'h0000FFEB, 1'b0);

    // Flush in cycle 10 of a DIV, then a MUL started in cycle 11
    prev = res0;
    @(posedge clk); #1;
    set_in(0, 1'b1, DIV, 32'd100, 32'd7);
    c0 = cyc;
    @(posedge clk); #1;
    set_in(0, 1'b0, DIV, 32'd0, 32'd0);
    repeat (9) @(posedge clk);
    #1 fl0 = 1'b1;
    @(negedge clk);
    chk("flush.busy_before", {31'b0, busy0}, 32'h1);
    @(posedge clk); #1;
    fl0 = 1'b0;
    set_in(0, 1'b1, MUL, 32'h00000007, 32'hFFFFFFFD);
    e.res  = 32'hFFFFFFEB;
    e.cyc  = c0 + 44;
    e.name = "mul_after_flush";
    push(0, e);
    @(negedge clk);
    chk("flush.busy_after", {31'b0, busy0}, 32'h0);
    chk("flush.result_kept", res0, prev);
    @(posedge clk); #1;
    set_in(0, 1'b0, MUL, 32'h0, 32'h0);
    wait_done(0, "mul_after_flush", 32);

    // Start held together with flush is dropped
    prev = res0;
    @(posedge clk); #1;
    set_in(0, 1'b1, DIVU, 32'd100, 32'd7);
    fl0 = 1'b1;
    @(posedge clk); #1;
    set_in(0, 1'b0, DIVU, 32'd0, 32'd0);
    fl0 = 1'b0;
    @(negedge clk);
    chk("flush_start.busy", {31'b0, busy0}, 32'h0);
    chk("flush_start.result", res0, prev);
    repeat (40) @(posedge clk);

    // Reset in cycle 5 of an op
    @(posedge clk); #1;
    set_in(0, 1'b1, MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    set_in(0, 1'b0, MULHU, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.busy",   {31'b0, busy0}, 32'h0);
    chk("rst_mid.done",   {31'b0, done0}, 32'h0);
    chk("rst_mid.result", res0, 32'h0);
    repeat (40) @(posedge clk);

    for (int w = 0; w < 3; w++) begin
      n_vec++;
      if (sb_size(w) != 0) begin
        n_bad++;
        $display("FAIL pending[%0d]: got %0d outstanding want 0", w, sb_size(w));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
